// File: rtl/alu_link_unit.sv
// Operate-class ALU/rotate stage over the 13-bit Link:AC pair with a busy/done handshake.
// Optional byte swap on op 9 is enabled by defining PDP8_BSW_EN.
module alu_link_unit #(
    parameter logic LINK_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] a,
    input  logic [11:0] b,
    input  logic [3:0]  op,
    input  logic        start,
    input  logic        cll,
    input  logic        cml,
    input  logic        oe,
    output logic [11:0] out,
    output logic        link,
    output logic        busy,
    output logic        done
);

    // The completion cycle is carried by done_q; the FSM is back in idle
    // during it, so a new start edge can follow two cycles after the last.
    typedef enum logic [0:0] {StIdle, StExec} state_e;

    state_e      state_q;
    logic        start_q;
    logic [3:0]  op_q;
    logic [11:0] b_q;
    logic [12:0] work_q;
    logic [1:0]  count_q;
    logic [11:0] result_q;
    logic        link_q;
    logic        done_q;

    logic        start_edge;
    logic        link_mod;
    logic [12:0] step_next;
    logic [12:0] sum;
    logic [12:0] inc;

    assign start_edge = start & ~start_q;

    always_comb begin
        link_mod = link_q;
        if (cll && cml) begin
            link_mod = 1'b1;
        end else if (cll) begin
            link_mod = 1'b0;
        end else if (cml) begin
            link_mod = ~link_q;
        end
    end

    // One execution step; work_q holds {L, AC}.
    always_comb begin
        sum       = {1'b0, work_q[11:0]} + {1'b0, b_q};
        inc       = {1'b0, work_q[11:0]} + 13'd1;
        step_next = work_q;
        case (op_q)
            4'd1: step_next = {work_q[12], work_q[11:0] & b_q};
            4'd2: step_next = {work_q[12] ^ sum[12], sum[11:0]};
            4'd3: step_next = {work_q[12] ^ inc[12], inc[11:0]};
            4'd4, 4'd5: step_next = {work_q[11:0], work_q[12]};
            4'd6, 4'd7: step_next = {work_q[0], work_q[12:1]};
            4'd8: step_next = {work_q[12], ~work_q[11:0]};
`ifdef PDP8_BSW_EN
            4'd9: step_next = {work_q[12], work_q[5:0], work_q[11:6]};
`endif
            default: step_next = work_q;
        endcase
    end

    always_ff @(posedge clk) begin
        start_q <= start;
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= 4'd0;
            b_q      <= 12'd0;
            work_q   <= 13'd0;
            count_q  <= 2'd0;
            result_q <= 12'd0;
            link_q   <= LINK_INIT;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    link_q <= link_mod;
                    if (start_edge) begin
                        op_q    <= op;
                        b_q     <= b;
                        work_q  <= {link_mod, a};
                        count_q <= (op == 4'd5 || op == 4'd7) ? 2'd2 : 2'd1;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    work_q  <= step_next;
                    count_q <= count_q - 2'd1;
                    if (count_q == 2'd1) begin
                        result_q <= step_next[11:0];
                        link_q   <= step_next[12];
                        done_q   <= 1'b1;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign out  = oe ? result_q : 12'd0;
    assign link = link_q;
    assign busy = (state_q == StExec);
    assign done = done_q;

endmodule

// File: tb/tb_alu_link_unit.sv
// Scoreboard bench for alu_link_unit: expected {link,result} pushed at issue, popped on done.
module tb_alu_link_unit;

    logic        clk = 1'b0;
    logic        reset, start, cll, cml, oe;
    logic [11:0] a, b;
    logic [3:0]  op;
    logic [11:0] out;
    logic        link, busy, done;

    int passed = 0;
    int total  = 0;
    logic        lmodel;
    logic [12:0] exp_q[$];

    alu_link_unit #(.LINK_INIT(1'b0)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .op(op), .start(start),
        .cll(cll), .cml(cml), .oe(oe), .out(out), .link(link), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] model(input logic [3:0] f, input logic [11:0] x,
                                          input logic [11:0] y, input logic l);
        logic [12:0] t, s;
        t = {l, x};
        case (f)
            4'd1: t = {l, x & y};
            4'd2: begin s = {1'b0, x} + {1'b0, y}; t = {l ^ s[12], s[11:0]}; end
            4'd3: begin s = {1'b0, x} + 13'd1; t = {l ^ s[12], s[11:0]}; end
            4'd4: t = {t[11:0], t[12]};
            4'd5: begin t = {t[11:0], t[12]}; t = {t[11:0], t[12]}; end
            4'd6: t = {t[0], t[12:1]};
            4'd7: begin t = {t[0], t[12:1]}; t = {t[0], t[12:1]}; end
            4'd8: t = {l, ~x};
`ifdef PDP8_BSW_EN
            4'd9: t = {l, x[5:0], x[11:6]};
`endif
            default: t = {l, x};
        endcase
        return t;
    endfunction

    // Issues one op after an idle gap and waits (bounded) for done; no checking here.
    task automatic run_op(input logic [3:0] f, input logic [11:0] x, input logic [11:0] y,
                          input logic c_l, input logic c_m, output int lat,
                          output logic busy_e0, output logic [11:0] o_out,
                          output logic o_link, output logic timed_out);
        logic [12:0] e;
        @(negedge clk);
        op = f; a = x; b = y; cll = c_l; cml = c_m; start = 1'b1;
        if (c_l && c_m) lmodel = 1'b1;
        else if (c_l) lmodel = 1'b0;
        else if (c_m) lmodel = ~lmodel;
        e = model(f, x, y, lmodel);
        exp_q.push_back(e);
        lmodel = e[12];
        timed_out = 1'b1; lat = 0; busy_e0 = 1'b0; o_out = 12'd0; o_link = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                busy_e0 = busy; start = 1'b0; cll = 1'b0; cml = 1'b0;
            end
            if (done) begin
                lat = k - 1; o_out = out; o_link = link; timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; cll = 1'b0; cml = 1'b0; oe = 1'b1;
        a = 12'd0; b = 12'd0; op = 4'd0;
        repeat (2) @(negedge clk);
        total++; if (out !== 12'd0) $display("FAIL reset_out got %o want 0", out); else passed++;
        total++; if (link !== 1'b0) $display("FAIL reset_link got %b want 0", link); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        reset = 1'b0; lmodel = 1'b0;
    endtask

    task automatic test_tad();
        int lat; logic be, ol, to; logic [11:0] oo; logic [12:0] e;
        oe = 1'b0;
        run_op(4'd2, 12'o7777, 12'o0001, 1'b1, 1'b0, lat, be, oo, ol, to);
        e = exp_q.pop_front();
        total++; if (to || lat != 1) $display("FAIL tad_latency got %0d to=%b want 1", lat, to);
        else passed++;
        total++; if (be !== 1'b1) $display("FAIL tad_busy got %b want 1", be); else passed++;
        total++; if (oo !== 12'd0) $display("FAIL tad_oe_low got %o want 0", oo); else passed++;
        total++; if (ol !== 1'b1) $display("FAIL tad_link got %b want 1", ol); else passed++;
        oe = 1'b1; #1;
        total++; if (out !== e[11:0] || out !== 12'o0000)
            $display("FAIL tad_result got %o want %o", out, e[11:0]);
        else passed++;
        run_op(4'd2, 12'o1234, 12'o0100, 1'b0, 1'b0, lat, be, oo, ol, to);
        e = exp_q.pop_front();
        total++; if (to || oo !== e[11:0] || ol !== e[12])
            $display("FAIL tad2 got %b:%o want %b:%o", ol, oo, e[12], e[11:0]);
        else passed++;
    endtask

    task automatic test_rotates();
        int lat; logic be, ol, to; logic [11:0] oo; logic [12:0] e;
        logic [3:0]  fs[4] = '{4'd5, 4'd6, 4'd7, 4'd4};
        logic [11:0] xs[4] = '{12'o3000, 12'o0001, 12'o0003, 12'o4001};
        int          ls[4] = '{2, 1, 2, 1};
        for (int i = 0; i < 4; i++) begin
            run_op(fs[i], xs[i], 12'd0, i < 3, i == 3, lat, be, oo, ol, to);
            e = exp_q.pop_front();
            total++; if (to || lat != ls[i] || be !== 1'b1)
                $display("FAIL rot%0d_timing got lat=%0d busy=%b to=%b want %0d", i, lat, be, to,
                         ls[i]);
            else passed++;
            total++; if (oo !== e[11:0] || ol !== e[12])
                $display("FAIL rot%0d_result got %b:%o want %b:%o", i, ol, oo, e[12], e[11:0]);
            else passed++;
            if (i == 0) begin
                total++; if (oo !== 12'o4000 || ol !== 1'b1)
                    $display("FAIL rtl_vector got %b:%o want 1:4000", ol, oo);
                else passed++;
            end
            if (i == 1) begin
                total++; if (oo !== 12'o0000 || ol !== 1'b1)
                    $display("FAIL rar_vector got %b:%o want 1:0000", ol, oo);
                else passed++;
            end
        end
    endtask

    task automatic test_link_ops();
        int lat; logic be, ol, to; logic [11:0] oo; logic [12:0] e;
        logic cls[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic cms[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic want[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); cll = cls[i]; cml = cms[i];
            @(negedge clk); cll = 1'b0; cml = 1'b0;
            total++; if (link !== want[i]) $display("FAIL linkop%0d got %b want %b", i, link,
                                                    want[i]);
            else passed++;
        end
        lmodel = 1'b0;
        run_op(4'd3, 12'o7777, 12'd0, 1'b0, 1'b1, lat, be, oo, ol, to);
        e = exp_q.pop_front();
        total++; if (to || oo !== 12'o0000 || ol !== 1'b0 || e !== {ol, oo})
            $display("FAIL cml_iac got %b:%o want 0:0000", ol, oo);
        else passed++;
    endtask

    task automatic test_handshake();
        int dones; logic [12:0] e;
        @(negedge clk);
        op = 4'd0; a = 12'o2525; b = 12'd0; start = 1'b1;
        exp_q.push_back(model(4'd0, 12'o2525, 12'd0, lmodel));
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 5) start = 1'b0;
            if (done) dones++;
        end
        e = exp_q.pop_front();
        total++; if (dones != 1) $display("FAIL held_start_dones got %0d want 1", dones);
        else passed++;
        total++; if (out !== e[11:0]) $display("FAIL held_start_out got %o want %o", out, e[11:0]);
        else passed++;
        // Second edge lands on the final EXEC step of RTR.
        @(negedge clk);
        op = 4'd7; a = 12'o0770; start = 1'b1;
        exp_q.push_back(model(4'd7, 12'o0770, 12'd0, lmodel));
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            start = (k == 1);
            if (done) dones++;
        end
        e = exp_q.pop_front();
        lmodel = e[12];
        total++; if (dones != 1) $display("FAIL rtr_reedge_dones got %0d want 1", dones);
        else passed++;
        total++; if (out !== e[11:0] || link !== e[12])
            $display("FAIL rtr_reedge_result got %b:%o want %b:%o", link, out, e[12], e[11:0]);
        else passed++;
    endtask

    task automatic test_reset_abort();
        int dones, busies;
        @(negedge clk);
        op = 4'd5; a = 12'o3000; cml = 1'b1; start = 1'b1;
        @(negedge clk); cml = 1'b0; reset = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL abort_flags got busy=%b done=%b want 0 0", busy, done);
        else passed++;
        total++; if (out !== 12'd0 || link !== 1'b0)
            $display("FAIL abort_state got %b:%o want 0:0000", link, out);
        else passed++;
        @(negedge clk); reset = 1'b0;
        dones = 0; busies = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done) dones++;
            if (busy) busies++;
        end
        start = 1'b0;
        total++; if (dones != 0 || busies != 0)
            $display("FAIL held_across_reset got dones=%0d busy=%0d want 0 0", dones, busies);
        else passed++;
        lmodel = 1'b0;
    endtask

    task automatic test_bsw();
        int lat; logic be, ol, to; logic [11:0] oo; logic [12:0] e; logic [11:0] want;
`ifdef PDP8_BSW_EN
        want = 12'o3412;
`else
        want = 12'o1234;
`endif
        run_op(4'd9, 12'o1234, 12'o7777, 1'b0, 1'b0, lat, be, oo, ol, to);
        e = exp_q.pop_front();
        total++; if (to || lat != 1 || oo !== want || oo !== e[11:0] || ol !== e[12])
            $display("FAIL bsw got %b:%o lat=%0d want %b:%o", ol, oo, lat, e[12], want);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int lat; logic be, ol, to; logic [11:0] oo; logic [12:0] e;
        logic [3:0]  fs[8] = '{4'd1, 4'd8, 4'd12, 4'd15, 4'd2, 4'd3, 4'd4, 4'd0};
        logic [11:0] xs[8] = '{12'o7070, 12'o1357, 12'o4444, 12'o0007, 12'o4000, 12'o0777,
                               12'o6000, 12'o5252};
        logic [11:0] ys[8] = '{12'o3333, 12'o0000, 12'o1111, 12'o7777, 12'o4000, 12'o0000,
                               12'o0000, 12'o1111};
        for (int i = 0; i < 8; i++) begin
            run_op(fs[i], xs[i], ys[i], 1'b0, i == 2, lat, be, oo, ol, to);
            e = exp_q.pop_front();
            total++; if (to || lat != 1 || oo !== e[11:0] || ol !== e[12])
                $display("FAIL b2b%0d op%0d got %b:%o lat=%0d want %b:%o", i, fs[i], ol, oo, lat,
                         e[12], e[11:0]);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_tad();
        test_rotates();
        test_link_ops();
        test_handshake();
        test_reset_abort();
        test_bsw();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
